// File: rtl/obj_sprite_engine_pkg.sv
// Shared types and constants for the sprite overlay engine.
// Optional per-slot blink storage is enabled by defining OBJ_BLINK_EN.
package obj_pkg;

  localparam int N_OBJ      = 8;
  localparam int IDX_W      = $clog2(N_OBJ);
  localparam int OBJ_W      = 10;
  localparam int SCR_W      = 320;
  localparam int SCR_H      = 240;
  localparam int SHEET_W    = 360;
  localparam int SHEET_SIZE = 86400;
  localparam int ANIM_SHIFT = 4;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] sx;
    logic [7:0] sy;
    logic       vis;
    logic       anim;
`ifdef OBJ_BLINK_EN
    logic       blink;
`endif
  } obj_desc_t;

endpackage

// File: rtl/obj_sprite_engine_if.sv
// Descriptor-write, raster-position and pixel-result signals of the sprite engine.
// wr_blink exists only when OBJ_BLINK_EN is defined.
interface obj_sprite_engine_if;
  import obj_pkg::*;

  // Strobes are single-cycle and unconditionally accepted: there is no ready/backpressure.
  logic             frame_start;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [8:0]       wr_x;
  logic [8:0]       wr_y;
  logic [8:0]       wr_sx;
  logic [7:0]       wr_sy;
  logic             wr_vis;
  logic             wr_anim;
`ifdef OBJ_BLINK_EN
  logic             wr_blink;
`endif
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [16:0]      pixel_addr;
  logic             isObject;
  logic [IDX_W-1:0] obj_idx;

`ifdef OBJ_BLINK_EN
  modport master (output frame_start, wr_en, wr_idx, wr_x, wr_y, wr_sx, wr_sy, wr_vis, wr_anim,
                  wr_blink, h_cnt, v_cnt, input pixel_addr, isObject, obj_idx);
  modport slave  (input frame_start, wr_en, wr_idx, wr_x, wr_y, wr_sx, wr_sy, wr_vis, wr_anim,
                  wr_blink, h_cnt, v_cnt, output pixel_addr, isObject, obj_idx);
`else
  modport master (output frame_start, wr_en, wr_idx, wr_x, wr_y, wr_sx, wr_sy, wr_vis, wr_anim,
                  h_cnt, v_cnt, input pixel_addr, isObject, obj_idx);
  modport slave  (input frame_start, wr_en, wr_idx, wr_x, wr_y, wr_sx, wr_sy, wr_vis, wr_anim,
                  h_cnt, v_cnt, output pixel_addr, isObject, obj_idx);
`endif

endinterface

// File: rtl/obj_sprite_engine_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request is set and the smallest set index.
module obj_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  output logic         o_hit,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_hit = 1'b1;
        o_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/obj_sprite_engine.sv
// Double-buffered sprite table with a 2-stage hit/address pipeline for the overlay layer.
// Define OBJ_BLINK_EN to add per-slot blinking on frame-counter bit ANIM_SHIFT+1.
module obj_sprite_engine
  import obj_pkg::*;
(
  input logic              clk,
  input logic              rst,
  obj_sprite_engine_if.slave obj_bus
);

  obj_desc_t        r_shadow [N_OBJ];
  obj_desc_t        r_active [N_OBJ];
  logic [7:0]       r_cnt;

  obj_desc_t        w_new;
  logic             w_wr_ok;
  logic [8:0]       w_x;
  logic [8:0]       w_y;
  logic             w_on_screen;
  logic [N_OBJ-1:0] w_hit_vec;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  obj_desc_t        w_win;

  logic             r_s1_hit;
  logic [IDX_W-1:0] r_s1_idx;
  logic [3:0]       r_s1_dx;
  logic [3:0]       r_s1_dy;
  logic [8:0]       r_s1_sx;
  logic [7:0]       r_s1_sy;
  logic             r_s1_alt;

  logic [17:0]      w_col;
  logic [17:0]      w_row;
  logic [17:0]      w_raw;
  logic [17:0]      w_addr;

  logic [16:0]      r_addr;
  logic             r_is_obj;
  logic [IDX_W-1:0] r_obj_idx;

  always_comb begin
    w_new      = '0;
    w_new.x    = obj_bus.wr_x;
    w_new.y    = obj_bus.wr_y;
    w_new.sx   = obj_bus.wr_sx;
    w_new.sy   = obj_bus.wr_sy;
    w_new.vis  = obj_bus.wr_vis;
    w_new.anim = obj_bus.wr_anim;
`ifdef OBJ_BLINK_EN
    w_new.blink = obj_bus.wr_blink;
`endif
  end

  assign w_wr_ok = obj_bus.wr_en && (int'(obj_bus.wr_idx) < N_OBJ);

  // A write coinciding with frame_start goes straight into the committed copy as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_cnt <= 8'd0;
    end else begin
      if (w_wr_ok) r_shadow[obj_bus.wr_idx] <= w_new;
      if (obj_bus.frame_start) begin
        for (int i = 0; i < N_OBJ; i++) begin
          r_active[i] <= (w_wr_ok && int'(obj_bus.wr_idx) == i) ? w_new : r_shadow[i];
        end
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign w_x         = obj_bus.h_cnt[9:1];
  assign w_y         = obj_bus.v_cnt[9:1];
  assign w_on_screen = (obj_bus.h_cnt < 10'd640) && (obj_bus.v_cnt < 10'd480);

  // Bounds are compared at 10 bits so objects near x=319/y=239 clip instead of wrapping.
  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      w_hit_vec[i] = w_on_screen && r_active[i].vis
`ifdef OBJ_BLINK_EN
                     && !(r_active[i].blink && r_cnt[ANIM_SHIFT+1])
`endif
                     && (w_x >= r_active[i].x)
                     && ({1'b0, w_x} < ({1'b0, r_active[i].x} + 10'(OBJ_W)))
                     && (w_y >= r_active[i].y)
                     && ({1'b0, w_y} < ({1'b0, r_active[i].y} + 10'(OBJ_W)));
    end
  end

  obj_prio_enc #(.N(N_OBJ), .W(IDX_W)) u_prio (
    .i_req (w_hit_vec),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  assign w_win = r_active[w_idx];

  // Sheet origin and animation phase are captured with the hit so a mid-line commit stays coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_hit <= 1'b0;
      r_s1_idx <= '0;
      r_s1_dx  <= 4'd0;
      r_s1_dy  <= 4'd0;
      r_s1_sx  <= 9'd0;
      r_s1_sy  <= 8'd0;
      r_s1_alt <= 1'b0;
    end else begin
      r_s1_hit <= w_hit;
      r_s1_idx <= w_idx;
      r_s1_dx  <= 4'(w_x - w_win.x);
      r_s1_dy  <= 4'(w_y - w_win.y);
      r_s1_sx  <= w_win.sx;
      r_s1_sy  <= w_win.sy;
      r_s1_alt <= w_win.anim && r_cnt[ANIM_SHIFT];
    end
  end

  assign w_col  = 18'(r_s1_sx) + 18'(r_s1_dx) + (r_s1_alt ? 18'(OBJ_W) : 18'd0);
  assign w_row  = 18'(r_s1_sy) + 18'(r_s1_dy);
  assign w_raw  = w_col + w_row * 18'(SHEET_W);
  assign w_addr = (w_raw >= 18'(SHEET_SIZE)) ? (w_raw - 18'(SHEET_SIZE)) : w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= 17'd0;
      r_is_obj  <= 1'b0;
      r_obj_idx <= '0;
    end else begin
      r_addr    <= r_s1_hit ? 17'(w_addr) : 17'd0;
      r_is_obj  <= r_s1_hit;
      r_obj_idx <= r_s1_hit ? r_s1_idx : '0;
    end
  end

  assign obj_bus.pixel_addr = r_addr;
  assign obj_bus.isObject   = r_is_obj;
  assign obj_bus.obj_idx    = r_obj_idx;

endmodule

// File: tb/tb_obj_sprite_engine.sv
// Directed and randomized checks of obj_sprite_engine against a table/arithmetic reference model.
module tb_obj_sprite_engine;
  import obj_pkg::*;

  typedef struct {
    int x, y, sx, sy;
    bit vis, anim, blink;
  } desc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  desc_t m_sh [N_OBJ];
  desc_t m_ac [N_OBJ];
  int    m_cnt = 0;
  bit    cur_blink = 1'b0;

  logic [20:0] exp_q[$];

  obj_sprite_engine_if bus ();

  obj_sprite_engine dut (
    .clk     (clk),
    .rst     (rst),
    .obj_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] ref_pix(input int h, input int v);
    int x, y, dx, dy, col, addr;
    if (h >= 640 || v >= 480) return '0;
    x = h / 2;
    y = v / 2;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!m_ac[i].vis) continue;
`ifdef OBJ_BLINK_EN
      if (m_ac[i].blink && ((m_cnt >> (ANIM_SHIFT + 1)) & 1) == 1) continue;
`endif
      if (x >= m_ac[i].x && x < m_ac[i].x + OBJ_W && y >= m_ac[i].y && y < m_ac[i].y + OBJ_W) begin
        dx   = x - m_ac[i].x;
        dy   = y - m_ac[i].y;
        col  = m_ac[i].sx + dx + ((m_ac[i].anim && ((m_cnt >> ANIM_SHIFT) & 1) == 1) ? OBJ_W : 0);
        addr = (col + (m_ac[i].sy + dy) * SHEET_W) % SHEET_SIZE;
        return {1'b1, 3'(i), 17'(addr)};
      end
    end
    return '0;
  endfunction

  function automatic logic [20:0] dut_out();
    return {bus.isObject, bus.obj_idx, bus.pixel_addr};
  endfunction

  task automatic check_val(input string tag, input logic [20:0] exp);
    logic [20:0] got;
    got = dut_out();
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got hit=%0b idx=%0d addr=%0d exp hit=%0b idx=%0d addr=%0d",
             tag, got[20], got[19:17], got[16:0], exp[20], exp[19:17], exp[16:0]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_OBJ; i++) begin
      m_sh[i] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      m_ac[i] = m_sh[i];
    end
    m_cnt = 0;
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input int sx, input int sy,
                            input bit vis, input bit anim, input bit with_commit);
    @(negedge clk);
    bus.wr_en       = 1'b1;
    bus.wr_idx      = 3'(idx);
    bus.wr_x        = 9'(x);
    bus.wr_y        = 9'(y);
    bus.wr_sx       = 9'(sx);
    bus.wr_sy       = 8'(sy);
    bus.wr_vis      = vis;
    bus.wr_anim     = anim;
`ifdef OBJ_BLINK_EN
    bus.wr_blink    = cur_blink;
`endif
    bus.frame_start = with_commit;
    @(negedge clk);
    bus.wr_en       = 1'b0;
    bus.frame_start = 1'b0;
    m_sh[idx] = '{x, y, sx, sy, vis, anim, cur_blink};
    if (with_commit) begin
      m_ac  = m_sh;
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic frame_tick();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    m_ac  = m_sh;
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic drive_pix(input int h, input int v);
    @(negedge clk);
    bus.h_cnt = 10'(h);
    bus.v_cnt = 10'(v);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_pix(input int h, input int v, input string tag);
    drive_pix(h, v);
    check_val(tag, ref_pix(h, v));
  endtask

  // Streams one pixel per cycle; each result is compared two cycles after it was driven.
  task automatic stream_pix(input int h, input int v, input string tag);
    @(negedge clk);
    if (exp_q.size() == 2) check_val(tag, exp_q.pop_front());
    bus.h_cnt = 10'(h);
    bus.v_cnt = 10'(v);
    exp_q.push_back(ref_pix(h, v));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_val(tag, exp_q.pop_front());
    end
  endtask

  task automatic sweep(input int hstep, input int vstep, input string tag);
    for (int v = 0; v < 500; v += vstep)
      for (int h = 0; h < 660; h += hstep)
        stream_pix(h, v, tag);
    drain(tag);
  endtask

  task automatic random_pixels(input int n, input string tag);
    int s, h, v;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(0, 679);
        v = $urandom_range(0, 499);
      end else begin
        s = $urandom_range(0, N_OBJ - 1);
        h = 2 * (m_ac[s].x + $urandom_range(0, OBJ_W)) + $urandom_range(0, 1);
        v = 2 * (m_ac[s].y + $urandom_range(0, OBJ_W)) + $urandom_range(0, 1);
      end
      stream_pix(h, v, tag);
    end
    drain(tag);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_idx      = '0;
    bus.wr_x        = '0;
    bus.wr_y        = '0;
    bus.wr_sx       = '0;
    bus.wr_sy       = '0;
    bus.wr_vis      = 1'b0;
    bus.wr_anim     = 1'b0;
`ifdef OBJ_BLINK_EN
    bus.wr_blink    = 1'b0;
`endif
    bus.h_cnt       = '0;
    bus.v_cnt       = '0;
    model_reset();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_outputs", 21'd0);
    sweep(13, 11, "empty_sweep");

    write_slot(0, 70, 40, 320, 30, 1'b1, 1'b0, 1'b0);
    frame_tick();
    drive_pix(140, 80);
    check_val("first_obj", {1'b1, 3'd0, 17'd11120});

    write_slot(0, 200, 40, 320, 30, 1'b1, 1'b0, 1'b0);
    drive_pix(140, 80);
    check_val("shadow_not_live", {1'b1, 3'd0, 17'd11120});
    frame_tick();
    drive_pix(140, 80);
    check_val("after_commit_moved", 21'd0);

    write_slot(0, 10, 10, 0, 0, 1'b1, 1'b0, 1'b1);
    drive_pix(20, 20);
    check_val("write_through_origin", {1'b1, 3'd0, 17'd0});
    drive_pix(39, 39);
    check_val("write_through_corner", {1'b1, 3'd0, 17'd3249});
    drive_pix(40, 20);
    check_val("right_edge_excl", 21'd0);

    write_slot(2, 95, 95, 0, 100, 1'b1, 1'b0, 1'b0);
    write_slot(5, 98, 98, 50, 0, 1'b1, 1'b0, 1'b1);
    drive_pix(200, 200);
    check_val("overlap_low_wins", {1'b1, 3'd2, 17'd37805});
    write_slot(2, 95, 95, 0, 100, 1'b0, 1'b0, 1'b1);
    drive_pix(200, 200);
    check_val("overlap_after_hide", {1'b1, 3'd5, 17'd772});

    write_slot(3, 0, 200, 100, 239, 1'b1, 1'b0, 1'b1);
    drive_pix(0, 418);
    check_val("sheet_wrap", {1'b1, 3'd3, 17'd2980});

    write_slot(4, 315, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    drive_pix(639, 0);
    check_val("clip_right", {1'b1, 3'd4, 17'd4});
    drive_pix(650, 0);
    check_val("h_out_of_range", 21'd0);
    write_slot(6, 100, 235, 0, 0, 1'b1, 1'b0, 1'b1);
    drive_pix(200, 480);
    check_val("v_out_of_range", 21'd0);
    check_pix(200, 479, "clip_bottom");

    write_slot(1, 300, 0, 320, 0, 1'b1, 1'b1, 1'b1);
    check_pix(600, 2, "anim_start");
    for (int f = 1; f <= 260; f++) begin
      frame_tick();
      if (f % 16 == 0 || f == 256) check_pix(600, 2, "anim_phase");
    end

    sweep(13, 11, "table_sweep");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_OBJ; i++) begin
`ifdef OBJ_BLINK_EN
        cur_blink = 1'($urandom_range(0, 1));
`endif
        write_slot(i, $urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 511),
                   $urandom_range(0, 255), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   (i == N_OBJ - 1));
      end
      random_pixels(400, "random_pix");
      repeat ($urandom_range(5, 40)) frame_tick();
      random_pixels(200, "random_pix_later");
    end

    drive_pix(2 * m_ac[0].x, 2 * m_ac[0].y);
    #1 rst = 1'b1;
    #1 check_val("reset_midframe", 21'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_pix(2 * 5, 2 * 5, "post_reset_empty");
    write_slot(7, 5, 5, 7, 3, 1'b1, 1'b1, 1'b1);
    drive_pix(10, 10);
    check_val("post_reset_cnt", {1'b1, 3'd7, 17'd1087});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_sprite_engine.md
Name: obj_sprite_engine

Overview:
- Pipelined, table-driven sprite address generator for the key/light/item overlay layer.
- Holds N_OBJ object descriptors (screen position, sheet origin, visibility, animation) in a double-buffered table that the stage FSM writes at any time; the table commits at frame start.
- Per VGA pixel, returns the sprite-sheet address and hit flag of the highest-priority visible object, for the pixel mux ahead of the background.

Parameters:
- N_OBJ, 8, number of object slots; index 0 has the highest priority.
- OBJ_W, 10, sprite width and height in half-resolution pixels.
- SHEET_W, 360, sprite-sheet row pitch in texels.
- SHEET_SIZE, 86400, sheet depth; addresses wrap modulo this value.
- ANIM_SHIFT, 4, frame-counter bit that selects the animation phase (toggles every 16 frames).

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle pulse at the start of vertical blank.
- wr_en  in  1  shadow-table write strobe.
- wr_idx  in  $clog2(N_OBJ)  slot to write.
- wr_x  in  9  object left x, 0..319.
- wr_y  in  9  object top y, 0..239.
- wr_sx  in  9  sheet column origin.
- wr_sy  in  8  sheet row origin.
- wr_vis  in  1  visible.
- wr_anim  in  1  two-phase animation enable.
- h_cnt  in  10  VGA column, 0..639.
- v_cnt  in  10  VGA row, 0..479.
- pixel_addr  out  17  sheet address.
- isObject  out  1  pixel belongs to a visible object.
- obj_idx  out  $clog2(N_OBJ)  index of the winning slot.

Behaviour:
- Reset:
  - Both tables cleared, so all slots are invisible.
  - Frame counter is 0.
  - pixel_addr, isObject and obj_idx are all 0.
- Shadow write:
  - wr_en=1 writes all descriptor fields of slot wr_idx on the clock edge.
  - wr_idx >= N_OBJ is ignored.
  - Back-to-back writes are allowed every cycle.
- Commit:
  - On frame_start, the active table loads the shadow table and the frame counter increments.
  - The counter is 8 bits and wraps from 255 to 0.
  - If wr_en and frame_start occur in the same cycle, the new write is included in the committed copy (write-through).
- Pixel path, 2-cycle latency:
  - Outputs in cycle n+2 correspond to h_cnt/v_cnt sampled in cycle n.
  - Stage 1:
    - x = h_cnt>>1, y = v_cnt>>1.
    - Slot i hits when vis=1, ox <= x < ox+OBJ_W and oy <= y < oy+OBJ_W.
    - h_cnt >= 640 or v_cnt >= 480 forces no hit.
    - A priority encoder selects the lowest hitting index.
    - Registers the index, dx = x-ox, dy = y-oy and the hit flag.
  - Stage 2:
    - col = sx + dx + (anim && cnt[ANIM_SHIFT] ? OBJ_W : 0).
    - addr = col + (sy+dy)*SHEET_W, computed at 18 bits.
    - If addr >= SHEET_SIZE, subtract SHEET_SIZE once.
    - Registers the result.
- No hit: isObject=0, pixel_addr=0, obj_idx=0.
- Edge cases:
  - Objects that extend past x=319 or y=239 are clipped naturally; there is no wrap on screen.
  - Overlapping objects: the lower index wins.
  - Reset mid-frame clears everything immediately; the first valid outputs appear 2 cycles after rst deasserts.

Optional Feature:
- Macro: OBJ_BLINK_EN.
- Defined:
  - Adds input wr_blink (1 bit), stored per slot in both tables.
  - A slot with blink=1 is treated as invisible while cnt[ANIM_SHIFT+1]=1.
- Undefined: the port and storage are absent, and behaviour is exactly as above.

Decomposition:
- Shared package obj_pkg:
  - obj_desc_t struct {x, y, sx, sy, vis, anim[, blink]}.
  - Constants SCR_W=320, SCR_H=240, SHEET_W, SHEET_SIZE.
- Sub-module obj_prio_enc: a parametrised N_OBJ-input lowest-index priority encoder that returns hit and index.

Test Plan:
- Reset then sweep a full frame -> isObject=0 everywhere; pixel_addr=0.
- Write slot 0 with x=70, y=40, sx=320, sy=30, vis=1, then frame_start; drive h_cnt=140, v_cnt=80 -> two cycles later, isObject=1, obj_idx=0, pixel_addr=320+30*360=11120.
- Write slot 0 without frame_start -> outputs unchanged until the next frame_start; assert wr_en and frame_start together -> the new data is active in the following frame.
- Slots 2 and 5 overlap at x=100, y=100 -> obj_idx=2; clear vis on slot 2 and commit -> obj_idx=5.
- Slot with anim=1, sx=320, after 16 frame_starts -> address offset +10 (330 column); after 16 more -> back to 320.
- Slot at sy=239, dy=9 -> raw address 248*360+sx ≥ 86400, wrapped by subtracting 86400; wr_idx=N_OBJ -> table unchanged; h_cnt=650 -> no hit.
